vip_gray_rank_filter_3x3: RTL and testbench

Parametrised 3x3 rank-order filter for the gray (Y) video path. It sits between the Y-extraction stage and the binarisation/edge stages. It builds its own 3x3 window from two internal line buffers and replicates border pixels. Per frame it outputs the median, minimum (erosion), maximum (dilation) or the unfiltered centre pixel.

---
 rtl/vip_gray_rank_filter_3x3.sv | 203 ++++++++++++++++++++
 tb/tb_vip_gray_rank_filter_3x3.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_gray_rank_filter_3x3.sv
// 3x3 rank-order filter (median / min / max / bypass) for the gray video path.
// Builds its own window from two line buffers, replicating border pixels.
module vip_gray_rank_filter_3x3 #(
    parameter int DATA_W    = 8,
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        rank_sel,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_y,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_y
);

    localparam int COL_W = $clog2(IMG_HDISP);
    localparam int ROW_W = $clog2(IMG_VDISP);

    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t mid3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [3:0]       r_vs_d;
    logic [3:0]       r_hr_d;
    logic [3:0]       r_ce_d;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [1:0]       r_mode;
    logic [1:0]       r_w_mode;
    logic [1:0]       r_s1_mode;
    logic [1:0]       r_s2_mode;
    pix_t             r_lb1 [IMG_HDISP];
    pix_t             r_lb2 [IMG_HDISP];
    pix_t             r_p   [3][3];
    pix_t             r_s1_max [3];
    pix_t             r_s1_mid [3];
    pix_t             r_s1_min [3];
    pix_t             r_s1_ctr;
    pix_t             r_s2_lo;
    pix_t             r_s2_md;
    pix_t             r_s2_hi;
    pix_t             r_s2_gmin;
    pix_t             r_s2_gmax;
    pix_t             r_s2_ctr;
    pix_t             r_out;

    logic w_valid;
    logic w_row0;
    logic w_row1;
    logic w_col0;
    pix_t w_cur [3];
    pix_t w_med;
    pix_t w_sel;

    assign w_valid = per_frame_clken & per_frame_href;
    assign w_row0  = (r_row == '0);
    assign w_row1  = (r_row == ROW_W'(1));
    assign w_col0  = (r_col == '0);

    // Row taps: rows above the frame fall back to the nearest real row.
    assign w_cur[2] = per_img_y;
    assign w_cur[1] = w_row0 ? per_img_y : r_lb1[r_col];
    assign w_cur[0] = w_row0 ? per_img_y :
                      (w_row1 ? r_lb1[r_col] : r_lb2[r_col]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d <= '0;
            r_hr_d <= '0;
            r_ce_d <= '0;
        end else begin
            r_vs_d <= {r_vs_d[2:0], per_frame_vsync};
            r_hr_d <= {r_hr_d[2:0], per_frame_href};
            r_ce_d <= {r_ce_d[2:0], per_frame_clken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= 2'b00;
        end else begin
            if (!per_frame_href)
                r_col <= '0;
            else if (per_frame_clken && r_col != COL_W'(IMG_HDISP - 1))
                r_col <= r_col + COL_W'(1);
            if (!per_frame_vsync)
                r_row <= '0;
            else if (r_hr_d[0] && !per_frame_href &&
                     r_row != ROW_W'(IMG_VDISP - 1))
                r_row <= r_row + ROW_W'(1);
            if (per_frame_vsync && !r_vs_d[0])
                r_mode <= rank_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (w_valid) begin
            r_lb1[r_col] <= per_img_y;
            r_lb2[r_col] <= r_lb1[r_col];
        end
    end

    // Column shift; at col 0 the whole window takes the current column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_p[i][j] <= '0;
            r_w_mode <= 2'b00;
        end else begin
            r_w_mode <= r_mode;
            if (w_valid) begin
                for (int i = 0; i < 3; i++) begin
                    r_p[i][0] <= w_col0 ? w_cur[i] : r_p[i][1];
                    r_p[i][1] <= w_col0 ? w_cur[i] : r_p[i][2];
                    r_p[i][2] <= w_cur[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_s1_max[i] <= '0;
                r_s1_mid[i] <= '0;
                r_s1_min[i] <= '0;
            end
            r_s1_ctr  <= '0;
            r_s1_mode <= 2'b00;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_s1_max[i] <= max2(max2(r_p[i][0], r_p[i][1]), r_p[i][2]);
                r_s1_mid[i] <= mid3(r_p[i][0], r_p[i][1], r_p[i][2]);
                r_s1_min[i] <= min2(min2(r_p[i][0], r_p[i][1]), r_p[i][2]);
            end
            r_s1_ctr  <= r_p[1][1];
            r_s1_mode <= r_w_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_lo   <= '0;
            r_s2_md   <= '0;
            r_s2_hi   <= '0;
            r_s2_gmin <= '0;
            r_s2_gmax <= '0;
            r_s2_ctr  <= '0;
            r_s2_mode <= 2'b00;
        end else begin
            r_s2_lo   <= min2(min2(r_s1_max[0], r_s1_max[1]), r_s1_max[2]);
            r_s2_md   <= mid3(r_s1_mid[0], r_s1_mid[1], r_s1_mid[2]);
            r_s2_hi   <= max2(max2(r_s1_min[0], r_s1_min[1]), r_s1_min[2]);
            r_s2_gmin <= min2(min2(r_s1_min[0], r_s1_min[1]), r_s1_min[2]);
            r_s2_gmax <= max2(max2(r_s1_max[0], r_s1_max[1]), r_s1_max[2]);
            r_s2_ctr  <= r_s1_ctr;
            r_s2_mode <= r_s1_mode;
        end
    end

    assign w_med = mid3(r_s2_lo, r_s2_md, r_s2_hi);

    always_comb begin
        w_sel = w_med;
        unique case (r_s2_mode)
            2'b00: w_sel = w_med;
            2'b01: w_sel = r_s2_gmin;
            2'b10: w_sel = r_s2_gmax;
            2'b11: w_sel = r_s2_ctr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_out <= '0;
        else
            r_out <= r_hr_d[2] ? w_sel : '0;
    end

    assign post_frame_vsync = r_vs_d[3];
    assign post_frame_href  = r_hr_d[3];
    assign post_frame_clken = r_ce_d[3];
    assign post_img_y       = r_out;

endmodule

// File: tb/tb_vip_gray_rank_filter_3x3.sv
// Bench for vip_gray_rank_filter_3x3: table of frames plus scoreboard
// queues; an 8-bit instance and a 12-bit bypass instance share controls.
module tb_vip_gray_rank_filter_3x3;

    localparam int H = 8;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rank_sel;
    logic [1:0]  rank_sel12;
    logic        vs, hr, ce;
    logic [7:0]  y8;
    logic [11:0] y12;
    logic        o_vs8, o_hr8, o_ce8;
    logic        o_vs12, o_hr12, o_ce12;
    logic [7:0]  o_y8;
    logic [11:0] o_y12;

    always #5 clk = ~clk;

    vip_gray_rank_filter_3x3 #(.DATA_W(8), .IMG_HDISP(H), .IMG_VDISP(V)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .rank_sel(rank_sel),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
        .per_img_y(y8),
        .post_frame_vsync(o_vs8), .post_frame_href(o_hr8),
        .post_frame_clken(o_ce8), .post_img_y(o_y8)
    );

    vip_gray_rank_filter_3x3 #(.DATA_W(12), .IMG_HDISP(H), .IMG_VDISP(V)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .rank_sel(rank_sel12),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
        .per_img_y(y12),
        .post_frame_vsync(o_vs12), .post_frame_href(o_hr12),
        .post_frame_clken(o_ce12), .post_img_y(o_y12)
    );

    typedef struct {
        int         pat;
        logic [1:0] mode;
        int         kind;
        int         gap;
        int         row [8];
    } vec_t;

    localparam int NV = 9;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] img [V][H];
    logic [7:0]  q8  [$];
    logic [11:0] q12 [$];
    logic [2:0]  hist [4];
    vec_t        tbl [NV];
    vec_t        cur;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cl(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int gold8(input int r, input int c, input logic [1:0] m);
        int v [9];
        int t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[i*3+j] = int'(img[cl(r-2+i)][cl(c-2+j)][7:0]);
        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 8 - a; b++)
                if (v[b] > v[b+1]) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        case (m)
            2'b00:   return v[4];
            2'b01:   return v[0];
            2'b10:   return v[8];
            default: return int'(img[cl(r-1)][cl(c-1)][7:0]);
        endcase
    endfunction

    function automatic int expect8(input int r, input int c);
        case (cur.kind)
            0:       return cur.row[c];
            1:       return (r >= 3 && r <= 5 && c >= 3 && c <= 5) ? 255 : 0;
            default: return gold8(r, c, cur.mode);
        endcase
    endfunction

    task automatic gen_img(input int pat);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                case (pat)
                    0:       img[r][c] = 12'd100;
                    1:       img[r][c] = (r == 3 && c == 3) ? 12'd255 : 12'd0;
                    2:       img[r][c] = 12'(10 * c);
                    default: img[r][c] = 12'($urandom);
                endcase
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
        chk("drain8", q8.size(), 0);
        chk("drain12", q12.size(), 0);
    endtask

    task automatic send_frame(input logic [1:0] mode, input int gap,
                              input int sw, input int abort_row);
        int c;
        rank_sel = mode;
        vs = 1'b1;
        repeat (3) @(negedge clk);
        for (int r = 0; r < V; r++) begin
            if (r == 2 && sw >= 0) rank_sel = 2'(sw);
            c = 0;
            while (c < H) begin
                if (r == abort_row && c == 5) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_vs", int'(o_vs8), 0);
                    chk("rst_hr", int'(o_hr8), 0);
                    chk("rst_ce", int'(o_ce8), 0);
                    chk("rst_y8", int'(o_y8), 0);
                    chk("rst_y12", int'(o_y12), 0);
                    vs = 1'b0; hr = 1'b0; ce = 1'b0;
                    q8.delete();
                    q12.delete();
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end
                hr = 1'b1;
                if (gap > 0 && $urandom_range(99) < gap) begin
                    ce  = 1'b0;
                    y12 = 12'($urandom);
                    y8  = 8'($urandom);
                end else begin
                    ce  = 1'b1;
                    y12 = img[r][c];
                    y8  = img[r][c][7:0];
                    q8.push_back(8'(expect8(r, c)));
                    q12.push_back(img[cl(r-1)][cl(c-1)]);
                    c++;
                end
                @(negedge clk);
            end
            hr = 1'b0; ce = 1'b0;
            repeat (3) @(negedge clk);
        end
        vs = 1'b0;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] = 3'b000;
        end else begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {vs, hr, ce};
            chk("ctl8", int'({o_vs8, o_hr8, o_ce8}), int'(hist[3]));
            chk("ctl12", int'({o_vs12, o_hr12, o_ce12}), int'(hist[3]));
            if (!o_hr8)
                chk("zero8", int'(o_y8), 0);
            else if (o_ce8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra8 actual=%0d required=none", o_y8);
                end else
                    chk("pix8", int'(o_y8), int'(q8.pop_front()));
            end
            if (!o_hr12)
                chk("zero12", int'(o_y12), 0);
            else if (o_ce12) begin
                if (q12.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra12 actual=%0d required=none", o_y12);
                end else
                    chk("pix12", int'(o_y12), int'(q12.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; vs = 1'b0; hr = 1'b0; ce = 1'b0;
        y8 = '0; y12 = '0; rank_sel = 2'b00; rank_sel12 = 2'b11;

        tbl[0] = '{pat:0, mode:2'b00, kind:0, gap:0,
                   row:'{100,100,100,100,100,100,100,100}};
        tbl[1] = '{pat:1, mode:2'b00, kind:0, gap:0, row:'{0,0,0,0,0,0,0,0}};
        tbl[2] = '{pat:1, mode:2'b10, kind:1, gap:0, row:'{0,0,0,0,0,0,0,0}};
        tbl[3] = '{pat:1, mode:2'b01, kind:0, gap:0, row:'{0,0,0,0,0,0,0,0}};
        tbl[4] = '{pat:2, mode:2'b01, kind:0, gap:0,
                   row:'{0,0,0,10,20,30,40,50}};
        tbl[5] = '{pat:2, mode:2'b10, kind:0, gap:0,
                   row:'{0,10,20,30,40,50,60,70}};
        tbl[6] = '{pat:3, mode:2'b00, kind:2, gap:0, row:'{0,0,0,0,0,0,0,0}};
        tbl[7] = '{pat:4, mode:2'b00, kind:2, gap:30, row:'{0,0,0,0,0,0,0,0}};
        tbl[8] = '{pat:3, mode:2'b11, kind:2, gap:30, row:'{0,0,0,0,0,0,0,0}};

        repeat (3) @(negedge clk);
        chk("reset_vs", int'(o_vs8), 0);
        chk("reset_hr", int'(o_hr8), 0);
        chk("reset_ce", int'(o_ce8), 0);
        chk("reset_y8", int'(o_y8), 0);
        chk("reset_y12", int'(o_y12), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            cur = tbl[i];
            if (cur.pat != 4) gen_img(cur.pat);
            send_frame(cur.mode, cur.gap, -1, -1);
            drain();
        end

        // mode switched mid-frame, then the following frame back-to-back
        cur.kind = 2;
        cur.mode = 2'b00;
        gen_img(3);
        send_frame(2'b00, 0, 2, -1);
        cur.mode = 2'b10;
        gen_img(3);
        send_frame(2'b10, 0, -1, -1);
        drain();

        // reset pulse mid-frame, then a clean gapped frame
        cur.mode = 2'b00;
        gen_img(3);
        send_frame(2'b00, 0, -1, 2);
        gen_img(3);
        send_frame(2'b00, 30, -1, -1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
